// File: rtl/pid_output_processor.sv
// PID output processor: converts signed per-channel PID results into
// sign/magnitude drive, with a per-channel PWM generator and a dead-time
// interlock that holds the output low for whole periods on direction reversal.
module pid_output_processor #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHN      = 4,
    parameter int CHN_WIDTH    = 3,
    parameter int DUTY_MAX     = 1023,
    parameter int DEAD_PERIODS = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  motor_en_i,
    input  logic                  pid_valid_i,
    input  logic [CHN_WIDTH-1:0]  pid_chn_i,
    input  logic [DATA_WIDTH-1:0] pid_data_i,
    output logic [NUM_CHN-1:0]    pwm_o,
    output logic [NUM_CHN-1:0]    dir_o
);

    localparam int CNT_W  = (DUTY_MAX < 2) ? 1 : $clog2(DUTY_MAX + 1);
    localparam int DEAD_W = (DEAD_PERIODS < 2) ? 1 : $clog2(DEAD_PERIODS + 1);

    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DUTY_MAX);
    localparam logic [DATA_WIDTH:0] DUTY_MAX_X = (DATA_WIDTH + 1)'(DUTY_MAX);
    localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_PERIODS - 1);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_DEAD = 1'b1;

    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                boundary;
    logic                wr_sign;
    logic [DATA_WIDTH:0] data_x;
    logic [DATA_WIDTH:0] mag_x;
    logic [CNT_W-1:0]    wr_mag;

    // Free-running period counter; the DUTY_MAX cycle is the period boundary
    always_comb begin
        boundary = (cnt_q == CNT_MAX);
        cnt_d    = boundary ? '0 : cnt_q + CNT_W'(1);
    end

    // Period counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Sign/magnitude of the incoming word; one extra bit so |min| cannot overflow
    always_comb begin
        wr_sign = pid_data_i[DATA_WIDTH-1];
        data_x  = {wr_sign, pid_data_i};
        mag_x   = wr_sign ? (~data_x + (DATA_WIDTH + 1)'(1)) : data_x;
        wr_mag  = (mag_x > DUTY_MAX_X) ? CNT_MAX : mag_x[CNT_W-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHN; gi++) begin : ch_g
            logic              wr_hit;
            logic              pend_sign_q, pend_sign_d;
            logic [CNT_W-1:0]  pend_mag_q, pend_mag_d;
            logic              state_q, state_d;
            logic [DEAD_W-1:0] dead_q, dead_d;
            logic [CNT_W-1:0]  duty_q, duty_d;
            logic              dir_q, dir_d;
            logic              pwm_q, pwm_d;

            // Pending command; the _d value is used at the boundary so a write
            // landing in the boundary cycle takes effect immediately
            always_comb begin
                wr_hit      = pid_valid_i && (pid_chn_i == CHN_WIDTH'(gi));
                pend_sign_d = wr_hit ? wr_sign : pend_sign_q;
                pend_mag_d  = wr_hit ? wr_mag  : pend_mag_q;
            end

            // Next-state logic for the RUN/DEAD interlock and active duty
            always_comb begin
                state_d = state_q;
                dead_d  = dead_q;
                duty_d  = duty_q;
                dir_d   = dir_q;
                if (!motor_en_i) begin
                    state_d = ST_RUN;
                    dead_d  = '0;
                    duty_d  = '0;
                end else if (boundary) begin
                    case (state_q)
                        ST_RUN: begin
                            // sign bit equals dir bit exactly when they disagree
                            if ((pend_mag_d != '0) && (pend_sign_d == dir_q)) begin
                                state_d = ST_DEAD;
                                dead_d  = '0;
                                duty_d  = '0;
                            end else begin
                                duty_d = pend_mag_d;
                            end
                        end
                        default: begin
                            if (dead_q == DEAD_LAST) begin
                                state_d = ST_RUN;
                                duty_d  = pend_mag_d;
                                if (pend_mag_d != '0) dir_d = ~pend_sign_d;
                            end else begin
                                dead_d = dead_q + DEAD_W'(1);
                            end
                        end
                    endcase
                end
            end

            // Output logic: PWM high while counter below active duty
            always_comb begin
                pwm_d = motor_en_i && (state_q == ST_RUN) && (cnt_q < duty_q);
            end

            // Channel state register
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    pend_sign_q <= 1'b0;
                    pend_mag_q  <= '0;
                    state_q     <= ST_RUN;
                    dead_q      <= '0;
                    duty_q      <= '0;
                    dir_q       <= 1'b1;
                    pwm_q       <= 1'b0;
                end else begin
                    pend_sign_q <= pend_sign_d;
                    pend_mag_q  <= pend_mag_d;
                    state_q     <= state_d;
                    dead_q      <= dead_d;
                    duty_q      <= duty_d;
                    dir_q       <= dir_d;
                    pwm_q       <= pwm_d;
                end
            end

            assign pwm_o[gi] = pwm_q;
            assign dir_o[gi] = dir_q;
        end
    endgenerate

endmodule

// File: tb/tb_pid_output_processor.sv
// Bench for pid_output_processor: per-cycle comparison against a behavioural
// model, table of duty/direction outcomes, and hand sequences for dead time,
// enable pulse and asynchronous reset.
module tb_pid_output_processor;

    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int CW   = 3;
    localparam int DMAX = 1023;
    localparam int DEAD = 2;
    localparam int PER  = DMAX + 1;

    logic           clk = 1'b0;
    logic           rstn;
    logic           motor_en_i;
    logic           pid_valid_i;
    logic [CW-1:0]  pid_chn_i;
    logic [DW-1:0]  pid_data_i;
    logic [NCH-1:0] pwm_o;
    logic [NCH-1:0] dir_o;

    pid_output_processor #(
        .DATA_WIDTH(DW), .NUM_CHN(NCH), .CHN_WIDTH(CW),
        .DUTY_MAX(DMAX), .DEAD_PERIODS(DEAD)
    ) dut (
        .clk(clk), .rstn(rstn), .motor_en_i(motor_en_i),
        .pid_valid_i(pid_valid_i), .pid_chn_i(pid_chn_i), .pid_data_i(pid_data_i),
        .pwm_o(pwm_o), .dir_o(dir_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: raw pending value, remaining dead periods, duty, dir
    int             m_pend [NCH];
    int             m_duty [NCH];
    int             m_dead [NCH];
    logic [NCH-1:0] m_dir;
    logic [NCH-1:0] m_pwm;
    int             m_cnt;

    typedef struct {
        int wr_chn;
        int data;
        int meas;
        int exp_dir;
        int exp_high;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_pend[n] = 0;
            m_duty[n] = 0;
            m_dead[n] = 0;
        end
        m_dir = '1;
        m_pwm = '0;
        m_cnt = 0;
    endfunction

    function automatic void model_step();
        logic [NCH-1:0] p;
        int mag;
        bit neg;
        for (int n = 0; n < NCH; n++)
            p[n] = motor_en_i && (m_dead[n] == 0) && (m_cnt < m_duty[n]);
        if (pid_valid_i && (int'(pid_chn_i) < NCH))
            m_pend[pid_chn_i] = int'($signed(pid_data_i));
        for (int n = 0; n < NCH; n++) begin
            neg = (m_pend[n] < 0);
            mag = neg ? -m_pend[n] : m_pend[n];
            if (mag > DMAX) mag = DMAX;
            if (!motor_en_i) begin
                m_duty[n] = 0;
                m_dead[n] = 0;
            end else if (m_cnt == DMAX) begin
                if (m_dead[n] == 0) begin
                    // reversal: commanded forward-ness differs from current dir
                    if (mag != 0 && ((!neg) != m_dir[n])) begin
                        m_dead[n] = DEAD;
                        m_duty[n] = 0;
                    end else begin
                        m_duty[n] = mag;
                    end
                end else begin
                    m_dead[n] = m_dead[n] - 1;
                    if (m_dead[n] == 0) begin
                        m_duty[n] = mag;
                        if (mag != 0) m_dir[n] = !neg;
                    end
                end
            end
        end
        m_cnt = (m_cnt == DMAX) ? 0 : m_cnt + 1;
        m_pwm = p;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_step();
        #1;
        chk("cyc_pwm", int'(pwm_o), int'(m_pwm));
        chk("cyc_dir", int'(dir_o), int'(m_dir));
    endtask

    task automatic wr(input int chn, input int data);
        pid_valid_i = 1'b1;
        pid_chn_i   = CW'(chn);
        pid_data_i  = DW'(data);
        tick();
        pid_valid_i = 1'b0;
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            tick();
            if (pwm_o[ch]) hi++;
        end
    endtask

    int hi;
    int any_hi;

    initial begin
        // wr_chn, data, meas_chn, exp_dir, exp_high
        tbl[0]  = '{0,    512, 0, 1,  512};
        tbl[1]  = '{1,    500, 1, 1,  500};
        tbl[2]  = '{1,   -300, 1, 0,  300};
        tbl[3]  = '{2,   2000, 2, 1, 1023};
        tbl[4]  = '{2, -32768, 2, 0, 1023};
        tbl[5]  = '{2,      0, 2, 0,    0};
        tbl[6]  = '{5,    400, 0, 1,  512};
        tbl[7]  = '{4,   -700, 1, 0,  300};
        tbl[8]  = '{3,      1, 3, 1,    1};
        tbl[9]  = '{3,   1023, 3, 1, 1023};
        tbl[10] = '{0,     -1, 0, 0,    1};
        tbl[11] = '{1,  32767, 1, 1, 1023};

        rstn        = 1'b0;
        motor_en_i  = 1'b0;
        pid_valid_i = 1'b0;
        pid_chn_i   = '0;
        pid_data_i  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_dir", int'(dir_o), 15);
        rstn       = 1'b1;
        motor_en_i = 1'b1;

        // write in the boundary cycle is used at that very boundary
        while (m_cnt != DMAX) tick();
        wr(1, 50);
        count_high(1, PER - 1, hi);
        chk("bnd_write_high", hi, 50);
        wr(1, 0);
        repeat (1100) tick();

        // table of single commands with settled outcome
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].wr_chn, tbl[i].data);
            repeat (3100) tick();
            count_high(tbl[i].meas, PER, hi);
            chk($sformatf("tbl%0d_high", i), hi, tbl[i].exp_high);
            chk($sformatf("tbl%0d_dir", i), int'(dir_o[tbl[i].meas]), tbl[i].exp_dir);
        end

        // two writes to ch3 in one period: only the latest is used
        while (m_cnt > 900) tick();
        wr(3, 100);
        repeat (5) tick();
        wr(3, 700);
        repeat (1100) tick();
        count_high(3, PER, hi);
        chk("overwrite_high", hi, 700);

        // dead time with the original sign rewritten during DEAD
        wr(0, 512);
        repeat (3100) tick();
        wr(0, -300);
        while (m_cnt != 0) tick();
        chk("dead_dir_hold", int'(dir_o[0]), 1);
        wr(0, 200);
        count_high(0, 1900, hi);
        chk("dead_low", hi, 0);
        repeat (1200) tick();
        count_high(0, PER, hi);
        chk("dead_after_high", hi, 200);
        chk("dead_after_dir", int'(dir_o[0]), 1);

        // enable pulse: pwm low next cycle, writes still accepted
        motor_en_i = 1'b0;
        tick();
        chk("en_off_pwm", int'(pwm_o), 0);
        wr(1, 400);
        repeat (8) tick();
        motor_en_i = 1'b1;
        repeat (1100) tick();
        count_high(1, PER, hi);
        chk("en_pending_high", hi, 400);

        // randomized traffic against the model
        for (int c = 0; c < 10000; c++) begin
            motor_en_i = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 39) == 0) begin
                int d;
                case ($urandom_range(0, 3))
                    0: d = int'($signed(DW'($urandom)));
                    1: d = $urandom_range(0, 1100) - 550;
                    2: d = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
                    default: d = 0;
                endcase
                pid_valid_i = 1'b1;
                pid_chn_i   = CW'($urandom_range(0, 7));
                pid_data_i  = DW'(d);
            end
            tick();
            pid_valid_i = 1'b0;
        end
        motor_en_i = 1'b1;
        wr(0, 600);
        wr(1, -600);
        wr(2, 900);
        wr(3, -50);
        repeat (3100) tick();

        // asynchronous reset mid-period with channels active
        while (m_cnt != 500) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_o), 0);
        chk("async_rst_dir", int'(dir_o), 15);
        model_reset();
        repeat (2) tick();
        rstn   = 1'b1;
        any_hi = 0;
        repeat (1500) begin
            tick();
            if (pwm_o != '0) any_hi++;
        end
        chk("post_rst_low", any_hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
